// File: rtl/auth_lock.sv
// Sequential passcode authenticator: edge-detected submit, one-cycle EVAL, OPEN/LOCKED states.
// Latency: submit rise sampled at edge k -> EVAL at k, matched/unmatched/open/locked/tries_left at k+1.
// Backpressure: none; submit rises outside READY are dropped, set_en/relock outside OPEN ignored.
//
// Ports:
//   clk_i, rst_i            single clock, synchronous active-high reset
//   submit_i, guess_i       guess strobe (rising edge starts an attempt) and guessed code
//   set_en_i, set_code_i    re-key request, honoured only while OPEN
//   relock_i                leave OPEN back to READY
//   matched_o, unmatched_o  one-cycle result pulses
//   open_o, locked_o        state decodes
//   tries_left_o            remaining attempts before lockout
module auth_lock #(
    parameter int unsigned          CODE_W       = 4,
    parameter int unsigned          MAX_TRIES    = 3,
    parameter int unsigned          LOCK_CYCLES  = 16,
    parameter logic [CODE_W-1:0]    DEFAULT_CODE = '0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             submit_i,
    input  logic [CODE_W-1:0]                guess_i,
    input  logic                             set_en_i,
    input  logic [CODE_W-1:0]                set_code_i,
    input  logic                             relock_i,
    output logic                             matched_o,
    output logic                             unmatched_o,
    output logic                             open_o,
    output logic                             locked_o,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left_o
);

    localparam int unsigned TW  = $clog2(MAX_TRIES + 1);
    localparam int unsigned LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_READY  = 2'd0,
        S_EVAL   = 2'd1,
        S_OPEN   = 2'd2,
        S_LOCKED = 2'd3
    } state_e;

    state_e              state_q,     state_d;
    logic [CODE_W-1:0]   code_q,      code_d;
    logic [CODE_W-1:0]   guess_q,     guess_d;
    logic [TW-1:0]       tries_q,     tries_d;
    logic [LCW-1:0]      lock_cnt_q,  lock_cnt_d;
    logic                matched_q,   matched_d;
    logic                unmatched_q, unmatched_d;
    logic                submit_q;
    logic                armed_q;
    logic                submit_rise;

    // armed_q stays low after reset until submit has been seen low once, so a
    // button held through reset release cannot start an attempt by itself.
    assign submit_rise = submit_i & ~submit_q & armed_q;

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        guess_d     = guess_q;
        tries_d     = tries_q;
        lock_cnt_d  = lock_cnt_q;
        matched_d   = 1'b0;
        unmatched_d = 1'b0;

        case (state_q)
            S_READY: begin
                if (submit_rise) begin
                    guess_d = guess_i;
                    state_d = S_EVAL;
                end
            end

            S_EVAL: begin
                if (guess_q == code_q) begin
                    matched_d = 1'b1;
                    tries_d   = TW'(MAX_TRIES);
                    state_d   = S_OPEN;
                end else begin
                    unmatched_d = 1'b1;
                    if (tries_q > TW'(1)) begin
                        tries_d = tries_q - TW'(1);
                        state_d = S_READY;
                    end else begin
                        // Last allowed miss; also covers a (never expected) zero count
                        // so the counter cannot wrap.
                        tries_d    = '0;
                        lock_cnt_d = LCW'(LOCK_CYCLES - 1);
                        state_d    = S_LOCKED;
                    end
                end
            end

            S_OPEN: begin
                if (set_en_i) begin
                    code_d = set_code_i;
                end
                if (relock_i) begin
                    state_d = S_READY;
                end
            end

            S_LOCKED: begin
                if (lock_cnt_q == '0) begin
                    tries_d = TW'(MAX_TRIES);
                    state_d = S_READY;
                end else begin
                    lock_cnt_d = lock_cnt_q - LCW'(1);
                end
            end

            default: begin
                state_d = S_READY;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_READY;
            code_q      <= DEFAULT_CODE;
            guess_q     <= '0;
            tries_q     <= TW'(MAX_TRIES);
            lock_cnt_q  <= '0;
            matched_q   <= 1'b0;
            unmatched_q <= 1'b0;
            submit_q    <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            guess_q     <= guess_d;
            tries_q     <= tries_d;
            lock_cnt_q  <= lock_cnt_d;
            matched_q   <= matched_d;
            unmatched_q <= unmatched_d;
            submit_q    <= submit_i;
            armed_q     <= armed_q | ~submit_i;
        end
    end

    assign matched_o    = matched_q;
    assign unmatched_o  = unmatched_q;
    assign open_o       = (state_q == S_OPEN);
    assign locked_o     = (state_q == S_LOCKED);
    assign tries_left_o = tries_q;

endmodule

// File: tb/tb_auth_lock.sv
// Directed bench for auth_lock with CODE_W=4, MAX_TRIES=3, LOCK_CYCLES=8, DEFAULT_CODE=4'hA.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants per scenario.
module tb_auth_lock;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       submit_i;
    logic [3:0] guess_i;
    logic       set_en_i;
    logic [3:0] set_code_i;
    logic       relock_i;
    logic       matched_o;
    logic       unmatched_o;
    logic       open_o;
    logic       locked_o;
    logic [1:0] tries_left_o;

    int n_vec = 0;
    int n_bad = 0;

    auth_lock #(
        .CODE_W       (4),
        .MAX_TRIES    (3),
        .LOCK_CYCLES  (8),
        .DEFAULT_CODE (4'hA)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .submit_i     (submit_i),
        .guess_i      (guess_i),
        .set_en_i     (set_en_i),
        .set_code_i   (set_code_i),
        .relock_i     (relock_i),
        .matched_o    (matched_o),
        .unmatched_o  (unmatched_o),
        .open_o       (open_o),
        .locked_o     (locked_o),
        .tries_left_o (tries_left_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Single submit pulse; returns just after the result edge (k+1) with the pulse visible.
    task automatic attempt(input string tag, input logic [3:0] g, input logic exp_match,
                           input logic [1:0] exp_tries);
        guess_i  = g;
        submit_i = 1'b1;
        step();                                  // edge k: EVAL
        chk({tag, "_eval_m"},  32'(matched_o),   32'd0);
        chk({tag, "_eval_u"},  32'(unmatched_o), 32'd0);
        submit_i = 1'b0;
        step();                                  // edge k+1: result
        chk({tag, "_m"},     32'(matched_o),    32'(exp_match));
        chk({tag, "_u"},     32'(unmatched_o),  32'(!exp_match));
        chk({tag, "_tries"}, 32'(tries_left_o), 32'(exp_tries));
    endtask

    task automatic do_relock();
        relock_i = 1'b1;
        step();
        relock_i = 1'b0;
        chk("relock_open", 32'(open_o), 32'd0);
    endtask

    initial begin
        int cnt;
        rst_i      = 1'b1;
        submit_i   = 1'b0;
        guess_i    = 4'h0;
        set_en_i   = 1'b0;
        set_code_i = 4'h0;
        relock_i   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_m",      32'(matched_o),    32'd0);
        chk("rst_u",      32'(unmatched_o),  32'd0);
        chk("rst_open",   32'(open_o),       32'd0);
        chk("rst_locked", 32'(locked_o),     32'd0);
        chk("rst_tries",  32'(tries_left_o), 32'd3);
        rst_i = 1'b0;
        step();

        // Default code matches
        attempt("t1", 4'hA, 1'b1, 2'd3);
        chk("t1_open", 32'(open_o), 32'd1);
        step();
        chk("t1_pulse_end", 32'(matched_o), 32'd0);
        do_relock();

        // Three misses -> lockout of exactly 8 cycles, submits ignored
        attempt("t2a", 4'h1, 1'b0, 2'd2);
        attempt("t2b", 4'h2, 1'b0, 2'd1);
        chk("t2b_locked", 32'(locked_o), 32'd0);
        attempt("t2c", 4'h3, 1'b0, 2'd0);
        chk("t2c_locked", 32'(locked_o), 32'd1);
        cnt = 1;
        for (int i = 2; i <= 8; i++) begin
            submit_i = (i == 3 || i == 5);
            guess_i  = 4'hA;
            step();
            if (locked_o) cnt++;
            chk("t2_lock_pulse", 32'(matched_o | unmatched_o), 32'd0);
        end
        submit_i = 1'b0;
        step();
        chk("t2_lock_cycles", 32'(cnt), 32'd8);
        chk("t2_unlocked",    32'(locked_o),     32'd0);
        chk("t2_tries_back",  32'(tries_left_o), 32'd3);
        step();
        chk("t2_no_late_pulse", 32'(matched_o | unmatched_o), 32'd0);

        // Re-key with relock in the same cycle
        attempt("t3a", 4'hA, 1'b1, 2'd3);
        set_en_i   = 1'b1;
        set_code_i = 4'h5;
        relock_i   = 1'b1;
        step();
        set_en_i = 1'b0;
        relock_i = 1'b0;
        chk("t3_ready", 32'(open_o), 32'd0);
        attempt("t3b", 4'hA, 1'b0, 2'd2);
        attempt("t3c", 4'h5, 1'b1, 2'd3);
        chk("t3c_open", 32'(open_o), 32'd1);
        set_en_i   = 1'b1;                       // put the code back to A, stay open
        set_code_i = 4'hA;
        step();
        set_en_i = 1'b0;
        chk("t3_still_open", 32'(open_o), 32'd1);
        do_relock();

        // Submit held high: one attempt only
        guess_i  = 4'h3;
        submit_i = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (unmatched_o) cnt++;
        end
        submit_i = 1'b0;
        step();
        chk("t4_one_pulse", 32'(cnt),          32'd1);
        chk("t4_tries",     32'(tries_left_o), 32'd2);
        set_en_i   = 1'b1;                       // ignored outside OPEN
        set_code_i = 4'h7;
        step();
        set_en_i = 1'b0;
        attempt("t4_code_kept", 4'hA, 1'b1, 2'd3);
        do_relock();

        // Reset during lockout
        attempt("t5a", 4'h1, 1'b0, 2'd2);
        attempt("t5b", 4'h2, 1'b0, 2'd1);
        attempt("t5c", 4'h3, 1'b0, 2'd0);
        step();
        step();
        step();
        chk("t5_mid_lock", 32'(locked_o), 32'd1);
        rst_i = 1'b1;
        step();
        chk("t5_rst_locked", 32'(locked_o),     32'd0);
        chk("t5_rst_open",   32'(open_o),       32'd0);
        chk("t5_rst_pulse",  32'(matched_o | unmatched_o), 32'd0);
        chk("t5_rst_tries",  32'(tries_left_o), 32'd3);
        rst_i = 1'b0;
        step();
        attempt("t5d", 4'hA, 1'b1, 2'd3);
        do_relock();

        // Reset during EVAL, submit held through reset release
        guess_i  = 4'hA;
        submit_i = 1'b1;
        step();                                  // EVAL
        rst_i = 1'b1;
        step();
        chk("t5e_rst_m",     32'(matched_o),    32'd0);
        chk("t5e_rst_open",  32'(open_o),       32'd0);
        chk("t5e_rst_tries", 32'(tries_left_o), 32'd3);
        rst_i = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (matched_o | unmatched_o | open_o) cnt++;
        end
        chk("t5e_held_no_attempt", 32'(cnt), 32'd0);
        submit_i = 1'b0;
        step();
        attempt("t5f", 4'hA, 1'b1, 2'd3);
        do_relock();

        // Correct guess restores the tries count
        attempt("t6a", 4'h1, 1'b0, 2'd2);
        attempt("t6b", 4'h2, 1'b0, 2'd1);
        attempt("t6c", 4'hA, 1'b1, 2'd3);
        do_relock();
        attempt("t6d", 4'h4, 1'b0, 2'd2);
        attempt("t6e", 4'h6, 1'b0, 2'd1);
        chk("t6e_locked", 32'(locked_o), 32'd0);
        attempt("t6f", 4'hF, 1'b0, 2'd0);
        chk("t6f_locked", 32'(locked_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
